// File: rtl/sseg_pkg.sv
// Shared definitions for the serial seven-segment display driver.
package sseg_pkg;

    localparam int NDIG = 8;

    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] HEX_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sseg_state_e;

endpackage

// File: rtl/hex7seg.sv
// One digit: hex value plus decimal point to an active-low segment byte {dp, gfedcba}.
module hex7seg
    import sseg_pkg::*;
(
    input  logic [3:0] val,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = {~dp, ~HEX_FONT[val]};
        if (blank) seg = 8'hFF;
    end

endmodule

// File: rtl/sseg_dev.sv
// Serial driver for an 8-digit seven-segment shift chain: encodes the hex word
// and shifts the 64-bit frame out MSB first on each Start rising edge.
module sseg_dev
    import sseg_pkg::*;
#(
    parameter int CLK_HALF = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        flash,
    input  logic [31:0] Hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  LES,
    output logic        seg_clk,
    output logic        seg_clrn,
    output logic        seg_sout,
    output logic        SEG_PEN
);

    localparam int          FRAME_W = 8 * NDIG;
    localparam logic [5:0]  BIT_LAST = 6'(FRAME_W - 1);
    localparam logic [15:0] PH_LAST  = 16'(CLK_HALF - 1);

    logic [FRAME_W-1:0] frame_p0;
    logic [FRAME_W-1:0] shreg_p1;
    sseg_state_e        state;
    logic               start_q1;
    logic               start_q2;
    logic               start_edge;
    logic [5:0]         bit_cnt;
    logic [15:0]        ph_cnt;

    // Stage p0: per-digit encoding, digit 7 lands in the top byte.
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        hex7seg u_hex7seg (
            .val   (Hexs[4*i +: 4]),
            .dp    (point[i]),
            .blank (LES[i] & flash),
            .seg   (frame_p0[8*i +: 8])
        );
    end

    // Edge detection works on registered Start, so a rise in the final SHIFT
    // cycle is still seen once the FSM is back in IDLE.
    assign start_edge = start_q1 & ~start_q2;

    // Stage p1: frame capture and serial shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q1 <= 1'b0;
            start_q2 <= 1'b0;
            bit_cnt  <= '0;
            ph_cnt   <= '0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            seg_clrn <= 1'b0;
            SEG_PEN  <= 1'b0;
        end else begin
            start_q1 <= Start;
            start_q2 <= start_q1;
            seg_clrn <= 1'b1;
            case (state)
                IDLE: begin
                    seg_clk  <= 1'b0;
                    seg_sout <= 1'b0;
                    SEG_PEN  <= 1'b1;
                    bit_cnt  <= '0;
                    ph_cnt   <= '0;
                    if (start_edge) begin
                        state    <= SHIFT;
                        shreg_p1 <= frame_p0;
                        seg_sout <= frame_p0[FRAME_W-1];
                        SEG_PEN  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (ph_cnt != PH_LAST) begin
                        ph_cnt <= ph_cnt + 16'd1;
                    end else begin
                        ph_cnt <= '0;
                        if (!seg_clk) begin
                            seg_clk <= 1'b1;
                        end else if (bit_cnt == BIT_LAST) begin
                            state    <= IDLE;
                            seg_clk  <= 1'b0;
                            seg_sout <= 1'b0;
                            SEG_PEN  <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 6'd1;
                            seg_clk  <= 1'b0;
                            seg_sout <= shreg_p1[FRAME_W-2];
                            shreg_p1 <= shreg_p1 << 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sseg_dev.sv
// Directed bench for sseg_dev: reset values, frame contents, timing and Start handling.
module tb_sseg_dev;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic        flash;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        seg_clk;
    logic        seg_clrn;
    logic        seg_sout;
    logic        SEG_PEN;

    int checks = 0;
    int errors = 0;

    sseg_dev #(.CLK_HALF(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .flash    (flash),
        .Hexs     (Hexs),
        .point    (point),
        .LES      (LES),
        .seg_clk  (seg_clk),
        .seg_clrn (seg_clrn),
        .seg_sout (seg_sout),
        .SEG_PEN  (SEG_PEN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Raises Start, drops it after 'hold' cycles, optionally re-pulses it at 'p2',
    // and records every bit seen on a seg_clk rising edge over 'win' cycles.
    task automatic capture(input int win, input int hold, input int p2,
                           output logic [63:0] fr, output int nedge, output int penlow);
        logic prev;
        fr = '0;
        nedge = 0;
        penlow = 0;
        prev = seg_clk;
        Start = 1'b1;
        for (int k = 0; k < win; k++) begin
            @(negedge clk);
            if (!SEG_PEN) penlow++;
            if (seg_clk && !prev) begin
                fr = {fr[62:0], seg_sout};
                nedge++;
            end
            prev = seg_clk;
            if (k == hold) Start = 1'b0;
            if (p2 > 0 && k == p2) Start = 1'b1;
            if (p2 > 0 && k == p2 + 3) Start = 1'b0;
        end
        Start = 1'b0;
    endtask

    task automatic frame_test(input string tag, input logic [63:0] exp);
        logic [63:0] fr;
        int ne, pl;
        capture(300, 2, 0, fr, ne, pl);
        chk({tag, "_frame"}, fr, exp);
        chk({tag, "_edges"}, 64'(ne), 64'd64);
        chk({tag, "_penlow"}, 64'(pl), 64'd128);
    endtask

    initial begin
        logic [63:0] fr;
        int ne, pl, cnt;
        logic prev;

        rst = 1'b1; Start = 1'b0; flash = 1'b0;
        Hexs = '0; point = '0; LES = '0;
        repeat (3) @(negedge clk);
        chk("rst_segclk", 64'(seg_clk), 64'd0);
        chk("rst_sout",   64'(seg_sout), 64'd0);
        chk("rst_clrn",   64'(seg_clrn), 64'd0);
        chk("rst_pen",    64'(SEG_PEN), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_clrn", 64'(seg_clrn), 64'd1);
        chk("rel_pen",  64'(SEG_PEN), 64'd1);
        repeat (3) @(negedge clk);

        Hexs = 32'h0300_0005; point = 8'h41;
        frame_test("pat1", 64'hC030_C0C0_C0C0_C012);

        Hexs = 32'h7654_3210; point = 8'h00;
        frame_test("pat2", 64'hF882_9299_B0A4_F9C0);

        LES = 8'h01; flash = 1'b1;
        frame_test("blink_on", 64'hF882_9299_B0A4_F9FF);
        flash = 1'b0;
        frame_test("blink_off", 64'hF882_9299_B0A4_F9C0);

        Hexs = 32'hFEDC_BA98; point = 8'hFF; LES = 8'h00;
        frame_test("hexhi", 64'h0E06_2146_0308_1000);
        LES = 8'hFF; flash = 1'b1;
        frame_test("all_dark", 64'hFFFF_FFFF_FFFF_FFFF);
        LES = 8'h00; flash = 1'b0;

        // Start held high for 500 cycles: one frame only.
        Hexs = 32'h7654_3210; point = 8'h00;
        capture(500, 500, 0, fr, ne, pl);
        chk("held_edges", 64'(ne), 64'd64);
        chk("held_frame", fr, 64'hF882_9299_B0A4_F9C0);
        repeat (3) @(negedge clk);

        // Second pulse mid-transfer, with inputs changed under it: ignored.
        capture(40, 2, 0, fr, ne, pl);
        Hexs = 32'h0000_0000;
        capture(260, 2, 0, fr, ne, pl);
        Hexs = 32'h7654_3210;
        repeat (3) @(negedge clk);
        capture(300, 2, 40, fr, ne, pl);
        chk("mid_pulse_edges", 64'(ne), 64'd64);

        // Start rising one cycle before the last SHIFT cycle: ignored.
        capture(400, 2, 127, fr, ne, pl);
        chk("late_pulse_edges", 64'(ne), 64'd64);

        // Start rising in the last SHIFT cycle: back-to-back second frame.
        capture(400, 2, 128, fr, ne, pl);
        chk("b2b_edges", 64'(ne), 64'd128);
        chk("b2b_penlow", 64'(pl), 64'd256);
        chk("b2b_frame", fr, 64'hF882_9299_B0A4_F9C0);

        // Reset during bit 20 aborts the transfer.
        Start = 1'b1;
        cnt = 0;
        prev = seg_clk;
        for (int k = 0; k < 200 && cnt < 20; k++) begin
            @(negedge clk);
            if (seg_clk && !prev) cnt++;
            prev = seg_clk;
            if (k == 2) Start = 1'b0;
        end
        Start = 1'b0;
        chk("abort_reached", 64'(cnt), 64'd20);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_segclk", 64'(seg_clk), 64'd0);
        chk("abort_sout",   64'(seg_sout), 64'd0);
        chk("abort_clrn",   64'(seg_clrn), 64'd0);
        chk("abort_pen",    64'(SEG_PEN), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle_pen", 64'(SEG_PEN), 64'd1);
        repeat (5) @(negedge clk);
        chk("abort_no_resume", 64'(SEG_PEN), 64'd1);
        frame_test("after_abort", 64'hF882_9299_B0A4_F9C0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
